// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot/debug loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;
  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [7:0] RESP_OK     = 8'h5A;
  localparam logic [7:0] RESP_ERR    = 8'hEE;

endpackage

// File: rtl/uart_loader_phy.sv
// UART byte PHY: rx synchronizer + deserializer with glitch and framing checks,
// and a start/8N/stop serializer. Both directions use byte strobes.
module uart_loader_phy
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_start_i,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    rx_sync_q;
  logic          rx_prev_q;
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_valid_q;
  logic          rx_err_q;
  logic          rx_s;

  assign rx_s           = rx_sync_q[1];
  assign rx_byte_o      = rx_shift_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_frame_err_o = rx_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchronizer and edge history reset to the idle level so that
      // leaving reset can never look like a falling start edge.
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere in clocked logic; the strobe defaults
      // below are overridden later in the same block without ordering races.
      rx_sync_q  <= {rx_sync_q[0], rx_i};
      rx_prev_q  <= rx_s;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CNT_FULL) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == CNT_FULL) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s) rx_valid_q <= 1'b1;
            else      rx_err_q   <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  logic          tx_q;
  logic          tx_busy_q;
  logic          tx_done_q;
  logic [8:0]    tx_frame_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;

  assign tx_o      = tx_q;
  assign tx_busy_o = tx_busy_q;
  assign tx_done_o = tx_done_q;

  // tx_bit_q: 0 = start bit, 1..8 = data, 9 = stop; tx_frame_q holds what is still to go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_frame_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        if (tx_start_i) begin
          tx_busy_q  <= 1'b1;
          tx_frame_q <= {1'b1, tx_byte_i};
          tx_q       <= 1'b0;
          tx_cnt_q   <= '0;
          tx_bit_q   <= '0;
        end
      end else if (tx_cnt_q == CNT_FULL) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
          tx_q      <= 1'b1;
        end else begin
          tx_q       <= tx_frame_q[0];
          tx_frame_q <= {1'b1, tx_frame_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART command loader: parses A5/cmd/addr/data frames from the host and
// masters one valid/ready memory transfer per frame, then replies over UART.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       tx_busy;
  logic       tx_done;

  loader_state_e state_q;
  logic          is_write_q;
  logic [1:0]    byte_cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          valid_q;
  logic [3:0]    wstrb_q;
  logic          busy_q;
  logic [TW-1:0] tmo_q;
  logic [31:0]   resp_q;
  logic [1:0]    resp_left_q;
  logic          sent_q;
  logic          tx_start_q;

  uart_loader_phy #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .clk           (clk),
    .rst_n         (rst),
    .rx_i          (uart_rx),
    .tx_o          (uart_tx),
    .rx_byte_o     (rx_byte),
    .rx_valid_o    (rx_valid),
    .rx_frame_err_o(rx_err),
    .tx_byte_i     (resp_q[7:0]),
    .tx_start_i    (tx_start_q),
    .tx_busy_o     (tx_busy),
    .tx_done_o     (tx_done)
  );

  assign memory_valid = valid_q;
  assign memory_instr = 1'b0;
  assign memory_addr  = addr_q;
  assign memory_wdata = wdata_q;
  assign memory_wstrb = wstrb_q;
  assign busy         = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      valid_q     <= 1'b0;
      wstrb_q     <= '0;
      busy_q      <= 1'b0;
      tmo_q       <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      sent_q      <= 1'b0;
      tx_start_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_byte == LOADER_SYNC) begin
            state_q <= ST_CMD;
            busy_q  <= 1'b1;
          end
        end
        ST_CMD: begin
          if (rx_err) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (rx_valid) begin
            if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
              is_write_q <= (rx_byte == CMD_WRITE);
              byte_cnt_q <= '0;
              state_q    <= ST_ADDR;
            end else begin
              resp_q      <= {24'h0, RESP_ERR};
              resp_left_q <= '0;
              sent_q      <= 1'b0;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (rx_err) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (rx_valid) begin
            addr_q     <= {rx_byte, addr_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (is_write_q) begin
                state_q <= ST_DATA;
              end else begin
                valid_q <= 1'b1;
                wstrb_q <= 4'b0000;
                tmo_q   <= '0;
                state_q <= ST_BUS;
              end
            end
          end
        end
        ST_DATA: begin
          if (rx_err) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (rx_valid) begin
            wdata_q    <= {rx_byte, wdata_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              valid_q <= 1'b1;
              wstrb_q <= 4'b1111;
              tmo_q   <= '0;
              state_q <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // valid_q is high for the whole of BUS, so ready alone marks the handshake.
          if (memory_ready) begin
            valid_q     <= 1'b0;
            wstrb_q     <= '0;
            resp_q      <= is_write_q ? {24'h0, RESP_OK} : memory_rdata;
            resp_left_q <= is_write_q ? 2'd0 : 2'd3;
            sent_q      <= 1'b0;
            state_q     <= ST_RESP;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            valid_q     <= 1'b0;
            wstrb_q     <= '0;
            resp_q      <= {24'h0, RESP_ERR};
            resp_left_q <= '0;
            sent_q      <= 1'b0;
            state_q     <= ST_RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_RESP: begin
          if (!sent_q && !tx_busy) begin
            tx_start_q <= 1'b1;
            sent_q     <= 1'b1;
          end else if (tx_done) begin
            if (resp_left_q == 2'd0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              resp_q      <= {8'h0, resp_q[31:8]};
              resp_left_q <= resp_left_q - 2'd1;
              sent_q      <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
